// File: rtl/inst_mem_fetch.sv
// Instruction memory with a program-load port, a registered valid/ready fetch path,
// flush on taken branches, and fault reporting for misaligned or out-of-range PCs.
module inst_mem_fetch #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter int                AW       = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] NOP_WORD = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       PC,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] Instruction,
    output logic [31:0]       rsp_pc,
    output logic              fault,
    output logic              running,
    output logic [AW:0]       load_count
);

    typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              nop_sel_q, nop_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic              fault_q, fault_d;
    logic [AW:0]       load_count_q, load_count_d;
    logic              accept_s, flush_s, write_s, pc_fault_s;

    function automatic logic pc_is_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (|pc[31:AW+2]);
    endfunction

    assign accept_s   = req_valid && req_ready;
    assign flush_s    = (state_q == ST_RUN) && flush;
    assign write_s    = (state_q == ST_LOAD) && load_en;
    assign pc_fault_s = pc_is_fault(PC);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: RUN is left only through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_LOAD;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_LOAD;
        endcase
    end

    // FSM outputs and request acceptance
    always_comb begin
        running   = (state_q == ST_RUN);
        req_ready = running && !flush && (!rsp_valid_q || rsp_ready);
    end

    // Storage array and its read register carry no reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (write_s) mem_q[load_addr] <= load_data;
        if (accept_s) rd_data_q <= mem_q[PC[AW+1:2]];
    end

    // Response next-state; flush takes priority over any other update
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_pc_d     = rsp_pc_q;
        fault_d      = fault_q;
        nop_sel_d    = nop_sel_q;
        load_count_d = load_count_q;
        if (flush_s) begin
            rsp_valid_d = 1'b0;
            nop_sel_d   = 1'b1;
        end else if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_pc_d    = PC;
            fault_d     = pc_fault_s;
            nop_sel_d   = pc_fault_s;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
        if (write_s && (load_count_q != (AW+1)'(DEPTH))) begin
            load_count_d = load_count_q + (AW+1)'(1);
        end else begin
            load_count_d = load_count_q;
        end
    end

    // Response and load-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_pc_q     <= 32'h0000_0000;
            fault_q      <= 1'b0;
            nop_sel_q    <= 1'b1;
            load_count_q <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_pc_q     <= rsp_pc_d;
            fault_q      <= fault_d;
            nop_sel_q    <= nop_sel_d;
            load_count_q <= load_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_pc      = rsp_pc_q;
    assign fault       = fault_q;
    assign load_count  = load_count_q;
    assign Instruction = nop_sel_q ? NOP_WORD : rd_data_q;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Scoreboard bench for inst_mem_fetch: expected responses are queued on accept and
// compared when the response appears.
module tb_inst_mem_fetch;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset, load_en, start, flush, req_valid, rsp_ready;
    logic [7:0]  load_addr;
    logic [31:0] load_data, PC;
    logic        req_ready, rsp_valid, fault, running;
    logic [31:0] Instruction, rsp_pc;
    logic [8:0]  load_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] model_mem [0:255];
    logic [31:0] prog [0:5] = '{32'hE3A00003, 32'hE3500000, 32'h0A000002,
                                32'hE2400001, 32'hEAFFFFFC, 32'hE3A0102A};
    logic [31:0] fpcs [0:3] = '{32'h0000_0006, 32'h0000_0400, 32'h0000_03FC, 32'hFFFF_FFFC};
    int total = 0;
    int bad   = 0;

    inst_mem_fetch dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready), .PC(PC), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .Instruction(Instruction), .rsp_pc(rsp_pc), .fault(fault), .running(running),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t r;
        r.pc = pc;
        if (pc[1:0] != 2'b00 || pc[31:10] != 22'd0) begin
            r.ins = NOP;
            r.flt = 1'b1;
        end else begin
            r.ins = model_mem[pc[9:2]];
            r.flt = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid, running, fault, Instruction, rsp_pc, load_count} !==
            {1'b0, 1'b0, 1'b0, NOP, 32'h0, 9'd0}) begin
            bad++;
            $display("FAIL reset_state: v=%b run=%b f=%b ins=%h pc=%h cnt=%0d want 0 0 0 %h 0 0",
                     rsp_valid, running, fault, Instruction, rsp_pc, load_count, NOP);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_load_and_fetch();
        for (int i = 0; i < 6; i++) begin
            load_en = 1'b1; load_addr = 8'(i); load_data = prog[i]; model_mem[i] = prog[i];
            tick();
        end
        load_en = 1'b0;
        @(negedge clk);
        total++;
        if ({load_count, running, req_ready} !== {9'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL load_count6: cnt=%0d run=%b rdy=%b want 6 0 0", load_count, running, req_ready);
        end
        tick();
        load_en = 1'b1; load_addr = 8'd255; load_data = 32'hE12FFF1E; start = 1'b1;
        model_mem[255] = 32'hE12FFF1E;
        tick();
        load_en = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if ({running, load_count} !== {1'b1, 9'd7}) begin
            bad++;
            $display("FAIL start_with_load: run=%b cnt=%0d want 1 7", running, load_count);
        end
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; PC = 32'(i) << 2;
            @(negedge clk);
            total++;
            if (req_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: pc=%h rdy=%b want 1", PC, req_ready);
            end
            sbq.push_back(mk(PC));
            if (i > 0) begin
                e = sbq.pop_front();
                total++;
                if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
                    bad++;
                    $display("FAIL b2b_rsp: v=%b pc=%h ins=%h f=%b want 1 %h %h %b",
                             rsp_valid, rsp_pc, Instruction, fault, e.pc, e.ins, e.flt);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
            bad++;
            $display("FAIL b2b_last: v=%b pc=%h ins=%h f=%b want 1 %h %h %b",
                     rsp_valid, rsp_pc, Instruction, fault, e.pc, e.ins, e.flt);
        end
        tick();
        @(negedge clk);
        total++;
        if ({rsp_valid, Instruction} !== {1'b0, 32'hE3A0102A}) begin
            bad++;
            $display("FAIL retire: v=%b ins=%h want 0 e3a0102a", rsp_valid, Instruction);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0; req_valid = 1'b1; PC = 32'h8;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept: rdy=%b want 1", req_ready);
        end
        sbq.push_back(mk(PC));
        tick();
        PC = 32'hC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, Instruction, rsp_pc, req_ready} !== {1'b1, 32'h0A000002, 32'h8, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold%0d: v=%b ins=%h pc=%h rdy=%b want 1 0a000002 8 0",
                         k, rsp_valid, Instruction, rsp_pc, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: rdy=%b want 1", req_ready);
        end
        e = sbq.pop_front();
        total++;
        if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
            bad++;
            $display("FAIL bp_rsp: v=%b pc=%h ins=%h want 1 %h %h", rsp_valid, rsp_pc, Instruction, e.pc, e.ins);
        end
        sbq.push_back(mk(PC));
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
            bad++;
            $display("FAIL bp_next: v=%b pc=%h ins=%h want 1 %h %h", rsp_valid, rsp_pc, Instruction, e.pc, e.ins);
        end
        tick();
    endtask

    task automatic test_faults();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; PC = fpcs[i];
            @(negedge clk);
            sbq.push_back(mk(PC));
            if (i > 0) begin
                e = sbq.pop_front();
                total++;
                if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
                    bad++;
                    $display("FAIL fault_rsp: v=%b pc=%h ins=%h f=%b want 1 %h %h %b",
                             rsp_valid, rsp_pc, Instruction, fault, e.pc, e.ins, e.flt);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
            bad++;
            $display("FAIL fault_last: v=%b pc=%h ins=%h f=%b want 1 %h %h %b",
                     rsp_valid, rsp_pc, Instruction, fault, e.pc, e.ins, e.flt);
        end
        tick();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b1; req_valid = 1'b1; PC = 32'h10;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_accept: rdy=%b want 1", req_ready);
        end
        tick();
        PC = 32'h14; flush = 1'b1;
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_pc, req_ready} !== {1'b1, 32'h10, 1'b0}) begin
            bad++;
            $display("FAIL flush_cycle: v=%b pc=%h rdy=%b want 1 10 0", rsp_valid, rsp_pc, req_ready);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({rsp_valid, Instruction} !== {1'b0, NOP}) begin
            bad++;
            $display("FAIL flush_after: v=%b ins=%h want 0 %h", rsp_valid, Instruction, NOP);
        end
        tick();
    endtask

    task automatic test_mode_gating();
        load_en = 1'b1; load_addr = 8'd0; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        @(negedge clk);
        total++;
        if (load_count !== 9'd7) begin
            bad++;
            $display("FAIL run_load_count: cnt=%0d want 7", load_count);
        end
        tick();
        req_valid = 1'b1; PC = 32'h0; rsp_ready = 1'b1;
        @(negedge clk);
        sbq.push_back(mk(PC));
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({rsp_valid, Instruction, fault} !== {1'b1, e.ins, e.flt} || e.ins !== 32'hE3A00003) begin
            bad++;
            $display("FAIL run_load_ignored: v=%b ins=%h want 1 e3a00003", rsp_valid, Instruction);
        end
        tick();
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; PC = 32'h4; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL ar_held: v=%b want 1", rsp_valid);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({rsp_valid, running} !== {1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ar_async: v=%b run=%b want 0 0", rsp_valid, running);
        end
        sbq.delete();
        tick();
        reset = 1'b0; req_valid = 1'b1; PC = 32'h0; rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({req_ready, load_count} !== {1'b0, 9'd0}) begin
            bad++;
            $display("FAIL load_mode_req: rdy=%b cnt=%0d want 0 0", req_ready, load_count);
        end
        tick();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_mode_rsp: v=%b want 0", rsp_valid);
        end
        tick();
        req_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; req_valid = 1'b1; PC = 32'h0;
        @(negedge clk);
        sbq.push_back(mk(PC));
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ar_restart_ready: rdy=%b want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if ({rsp_valid, rsp_pc, Instruction, fault} !== {1'b1, e.pc, e.ins, e.flt}) begin
            bad++;
            $display("FAIL ar_retained: v=%b pc=%h ins=%h want 1 %h %h", rsp_valid, rsp_pc, Instruction, e.pc, e.ins);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; start = 1'b0; flush = 1'b0; req_valid = 1'b0;
        rsp_ready = 1'b0; load_addr = 8'd0; load_data = 32'h0; PC = 32'h0;
        test_reset();
        test_load_and_fetch();
        test_backpressure();
        test_faults();
        test_flush();
        test_mode_gating();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
